// File: rtl/yoda_pkg.sv
// yoda_pkg: shared constants and collector state type for the encrypter array.
package yoda_pkg;
    localparam int NUM_ENCRYPTERS       = 4;
    localparam int ENCRYPTER_WIDTH      = 32;
    localparam int NIBBLE_WIDTH         = 4;
    localparam int COUNT_WIDTH          = 16;
    localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / NIBBLE_WIDTH;
    localparam int LANE_WIDTH           = $clog2(NUM_ENCRYPTERS);
    localparam int NIB_IDX_WIDTH        = $clog2(ENCRYPTER_QSPI_COUNT);
    typedef enum logic [1:0] {IDLE, WAIT, SHIFT} collector_state_e;
endpackage

// File: rtl/encrypter_collector_if.sv
// encrypter_collector_if: per-lane result handshake plus the nibble output stream.
interface encrypter_collector_if import yoda_pkg::*;;
    logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0] enc_result_data;
    logic [NUM_ENCRYPTERS-1:0] enc_result_valid;
    logic [NUM_ENCRYPTERS-1:0] enc_result_ack;
    logic [NIBBLE_WIDTH-1:0] qspi_out_data;
    logic qspi_out_valid;
    logic qspi_out_ready;
    modport master (
        input  enc_result_data, enc_result_valid, qspi_out_ready,
        output enc_result_ack, qspi_out_data, qspi_out_valid
    );
    modport slave (
        output enc_result_data, enc_result_valid, qspi_out_ready,
        input  enc_result_ack, qspi_out_data, qspi_out_valid
    );
endinterface

// File: rtl/nibble_shifter.sv
// nibble_shifter: shifts a loaded packet out LSB nibble first over valid/ready,
// pulsing done as the last nibble is accepted.
module nibble_shifter import yoda_pkg::*; (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [ENCRYPTER_WIDTH-1:0] packet,
    input  logic                       ready,
    output logic                       valid,
    output logic [NIBBLE_WIDTH-1:0]    data,
    output logic                       done
);
    logic [ENCRYPTER_WIDTH-1:0] buf_q;
    logic [NIB_IDX_WIDTH-1:0] nib_idx;
    assign data = buf_q[nib_idx*NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign done = valid && ready && nib_idx == NIB_IDX_WIDTH'(ENCRYPTER_QSPI_COUNT - 1);
    // load wins over completion so a reload on the last nibble keeps valid high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q   <= '0;
            nib_idx <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            buf_q   <= packet;
            nib_idx <= '0;
            valid   <= 1'b1;
        end else if (valid && ready) begin
            nib_idx <= done ? '0 : nib_idx + 1'b1;
            valid   <= !done;
        end
    end
endmodule

// File: rtl/encrypter_collector.sv
// encrypter_collector: round-robin collection of encrypter packets onto a nibble stream.
// Define COLLECTOR_DOUBLE_BUF_EN for a holding register giving back-to-back packets.
module encrypter_collector import yoda_pkg::*; (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   flush,
    encrypter_collector_if.master  bus,
    output logic                   qspi_out_sending,
    output logic [LANE_WIDTH-1:0]  lane_ptr_out,
    output logic [COUNT_WIDTH-1:0] packets_sent
);
    collector_state_e state, state_nxt;
    logic [LANE_WIDTH-1:0] lane_ptr;
    logic [NUM_ENCRYPTERS-1:0] ack;
    logic [ENCRYPTER_WIDTH-1:0] load_pkt;
    logic lane_valid, take, load, done;
    assign lane_valid = bus.enc_result_valid[lane_ptr];
    assign bus.enc_result_ack = ack;
    assign qspi_out_sending = state != IDLE;
    assign lane_ptr_out = lane_ptr;
`ifdef COLLECTOR_DOUBLE_BUF_EN
    logic [ENCRYPTER_WIDTH-1:0] hold;
    logic hold_full;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (state == SHIFT && take) begin
            hold      <= bus.enc_result_data[lane_ptr];
            hold_full <= 1'b1;
        end else if (state == SHIFT && load) begin
            hold_full <= 1'b0;
        end
    end
`endif
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        load      = 1'b0;
        load_pkt  = bus.enc_result_data[lane_ptr];
        case (state)
            IDLE: state_nxt = start ? WAIT : IDLE;
            WAIT: begin
                take      = !flush && lane_valid;
                load      = take;
                state_nxt = flush ? IDLE : (lane_valid ? SHIFT : WAIT);
            end
            SHIFT: begin
`ifdef COLLECTOR_DOUBLE_BUF_EN
                // skip the ack cycle so a still-asserted valid is never captured twice
                take     = !hold_full && lane_valid && !done && ack == '0;
                load     = done && hold_full;
                load_pkt = hold;
                if (done && !hold_full) state_nxt = flush ? IDLE : WAIT;
`else
                if (done) state_nxt = flush ? IDLE : WAIT;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lane_ptr     <= '0;
            ack          <= '0;
            packets_sent <= '0;
        end else begin
            state <= state_nxt;
            ack   <= '0;
            if (state == IDLE && start) lane_ptr <= '0;
            if (take) begin
                ack[lane_ptr] <= 1'b1;
                lane_ptr      <= lane_ptr == LANE_WIDTH'(NUM_ENCRYPTERS - 1) ? '0 : lane_ptr + 1'b1;
            end
            if (done) packets_sent <= packets_sent + 1'b1;
        end
    end
    nibble_shifter u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .packet (load_pkt),
        .ready  (bus.qspi_out_ready),
        .valid  (bus.qspi_out_valid),
        .data   (bus.qspi_out_data),
        .done   (done)
    );
endmodule

// File: tb/tb_encrypter_collector.sv
// tb_encrypter_collector: table-driven packets plus corner-case sequences, nibble scoreboard.
module tb_encrypter_collector;
    import yoda_pkg::*;
    logic clk = 1'b0;
    logic reset, start, flush;
    logic qspi_out_sending;
    logic [LANE_WIDTH-1:0] lane_ptr_out;
    logic [COUNT_WIDTH-1:0] packets_sent;
    encrypter_collector_if bus();
    encrypter_collector dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .flush            (flush),
        .bus              (bus),
        .qspi_out_sending (qspi_out_sending),
        .lane_ptr_out     (lane_ptr_out),
        .packets_sent     (packets_sent)
    );
    always #5 clk = ~clk;
    typedef struct {
        int          lane;
        logic [31:0] data;
        logic [31:0] exp_ptr;
        logic [31:0] exp_sent;
    } vec_t;
    vec_t vecs[8];
    int cmp = 0, fails = 0, ack_total = 0, exp_lane = 0, rk = 0;
    logic [NIBBLE_WIDTH-1:0] sb[$];
    logic toggle = 1'b0;
    logic prev_stall = 1'b0;
    logic [NIBBLE_WIDTH-1:0] prev_data = '0;
    logic [NUM_ENCRYPTERS-1:0] prev_ack = '0;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push_pkt(logic [31:0] d);
        for (int k = 0; k < ENCRYPTER_QSPI_COUNT; k++) sb.push_back(d[k*4 +: 4]);
    endtask
    task automatic send(int lane, logic [31:0] d);
        bus.enc_result_data[lane] = d;
        bus.enc_result_valid[lane] = 1'b1;
        push_pkt(d);
    endtask
    task automatic do_start();
        start = 1'b1;
        exp_lane = 0;
        tick(1);
        start = 1'b0;
    endtask
    task automatic drain(string name);
        int i = 0;
        while ((sb.size() != 0 || bus.qspi_out_valid) && i < 200) begin
            tick(1);
            i++;
        end
        check(name, 32'(sb.size()), 0);
    endtask
    task automatic wait_valid(string name);
        int i = 0;
        while (!bus.qspi_out_valid && i < 50) begin
            tick(1);
            i++;
        end
        check(name, 32'(bus.qspi_out_valid), 1);
    endtask
    task automatic check_zero(string tag);
        check({tag, "_sending"}, 32'(qspi_out_sending), 0);
        check({tag, "_valid"}, 32'(bus.qspi_out_valid), 0);
        check({tag, "_data"}, 32'(bus.qspi_out_data), 0);
        check({tag, "_ack"}, 32'(bus.enc_result_ack), 0);
        check({tag, "_lane_ptr"}, 32'(lane_ptr_out), 0);
        check({tag, "_sent"}, 32'(packets_sent), 0);
    endtask
    // sink ready: always high, or a repeating 1,0,0 pattern
    always @(posedge clk) begin
        #1;
        bus.qspi_out_ready = toggle ? (rk % 3 == 0) : 1'b1;
        rk++;
    end
    // scoreboard pop, stall stability and ack ordering; upstream drops valid once acked
    always @(negedge clk) begin
        if (prev_stall) check("hold_stable", 32'(bus.qspi_out_data), 32'(prev_data));
        prev_stall = bus.qspi_out_valid && !bus.qspi_out_ready;
        prev_data = bus.qspi_out_data;
        if (bus.qspi_out_valid && bus.qspi_out_ready) begin
            if (sb.size() == 0) check("spurious_nibble", 32'(sb.size()), 1);
            else check("nibble", 32'(bus.qspi_out_data), 32'(sb.pop_front()));
        end
        if (bus.enc_result_ack != '0) begin
            check("ack_lane", 32'(bus.enc_result_ack), 32'(1) << exp_lane);
            check("ack_single_cycle", 32'(prev_ack), 0);
            for (int i = 0; i < NUM_ENCRYPTERS; i++)
                if (bus.enc_result_ack[i]) bus.enc_result_valid[i] = 1'b0;
            exp_lane = (exp_lane + 1) % NUM_ENCRYPTERS;
            ack_total++;
        end
        prev_ack = bus.enc_result_ack;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1);
    end
    initial begin
        int n, gaps, acks, exp_gaps;
        vecs[0] = '{0, 32'h11111111, 1, 1};
        vecs[1] = '{1, 32'h22222222, 2, 2};
        vecs[2] = '{2, 32'h33333333, 3, 3};
        vecs[3] = '{3, 32'h44444444, 0, 4};
        vecs[4] = '{0, 32'hDEADBEEF, 1, 5};
        vecs[5] = '{1, 32'h0F1E2D3C, 2, 6};
        vecs[6] = '{2, 32'hFFFFFFFF, 3, 7};
        vecs[7] = '{3, 32'h00000000, 0, 8};
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        bus.enc_result_valid = '0;
        bus.enc_result_data = '0;
        bus.qspi_out_ready = 1'b1;
        tick(3);
        check_zero("reset");
        reset = 1'b1;
        flush = 1'b1;
        tick(2);
        check("idle_flush_ignored", 32'(qspi_out_sending), 0);
        flush = 1'b0;
        do_start();
        check("sending_after_start", 32'(qspi_out_sending), 1);
        foreach (vecs[i]) begin
            send(vecs[i].lane, vecs[i].data);
            drain("tbl_drain");
            check("tbl_lane_ptr", 32'(lane_ptr_out), vecs[i].exp_ptr);
            check("tbl_sent", 32'(packets_sent), vecs[i].exp_sent);
        end
        check("tbl_ack_count", 32'(ack_total), 8);
        toggle = 1'b1;
        send(0, 32'h87654321);
        drain("ready_toggle_drain");
        toggle = 1'b0;
        check("ready_toggle_sent", 32'(packets_sent), 9);
        acks = ack_total;
        bus.enc_result_data[2] = 32'hCAFEF00D;
        bus.enc_result_valid[2] = 1'b1;
        tick(6);
        check("ooo_no_ack", 32'(ack_total), 32'(acks));
        check("ooo_no_valid", 32'(bus.qspi_out_valid), 0);
        send(1, 32'h5A5A1234);
        push_pkt(32'hCAFEF00D);
        drain("ooo_drain");
        check("ooo_lane_ptr", 32'(lane_ptr_out), 3);
        check("ooo_sent", 32'(packets_sent), 11);
        send(3, 32'hA5C3F01E);
        wait_valid("flush_first_valid");
        tick(2);
        flush = 1'b1;
        drain("flush_drain");
        check("flush_sending", 32'(qspi_out_sending), 0);
        check("flush_sent", 32'(packets_sent), 12);
        flush = 1'b0;
        acks = ack_total;
        for (int i = 0; i < NUM_ENCRYPTERS; i++) send(i, 32'h1 << i);
        sb.delete();
        tick(10);
        check("idle_no_ack", 32'(ack_total), 32'(acks));
        check("idle_no_valid", 32'(bus.qspi_out_valid), 0);
        bus.enc_result_valid = '0;
        do_start();
        send(0, 32'h0BADF00D);
        wait_valid("rst_first_valid");
        tick(4);
        #1 reset = 1'b0;
        #1 check_zero("async_reset");
        sb.delete();
        bus.enc_result_valid = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
        do_start();
        send(0, 32'h13579BDF);
        drain("post_reset_drain");
        check("post_reset_sent", 32'(packets_sent), 1);
        check("post_reset_lane_ptr", 32'(lane_ptr_out), 1);
        send(1, 32'h01234567);
        send(2, 32'h89ABCDEF);
        send(3, 32'hF0E1D2C3);
        send(0, 32'hB4A59687);
        wait_valid("burst_first_valid");
        n = 0;
        gaps = 0;
        for (int i = 0; i < 100 && n < 32; i++) begin
            @(negedge clk);
            if (bus.qspi_out_valid && bus.qspi_out_ready) n++;
            else gaps++;
        end
`ifdef COLLECTOR_DOUBLE_BUF_EN
        exp_gaps = 0;
`else
        exp_gaps = 3;
`endif
        check("burst_nibbles", 32'(n), 32);
        check("burst_gaps", 32'(gaps), 32'(exp_gaps));
        tick(1);
        drain("burst_drain");
        check("burst_sent", 32'(packets_sent), 5);
        check("burst_lane_ptr", 32'(lane_ptr_out), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", cmp, fails);
        $finish;
    end
endmodule

// File: doc/encrypter_collector.md
Name: encrypter_collector

Overview:
- Downstream stage of the encrypter array; consumes the per-encrypter ciphertext packets.
- Collects packets in strict round-robin order, starting at encrypter 0. This is the same order the upstream distributor dispatches in, so stream order is preserved.
- Serialises each packet onto a 4-bit nibble output stream with a valid/ready handshake, for the return QSPI path.

Parameters:
- NUM_ENCRYPTERS, 4, number of encrypter lanes.
- ENCRYPTER_WIDTH, 32, packet width in bits; must be a multiple of 4.
- COUNT_WIDTH, 16, width of the packets-sent counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; opens a session.
- flush  input  1  level; ends a session once the current packet has drained.
- enc_result_data  input  NUM_ENCRYPTERS x ENCRYPTER_WIDTH  per-lane ciphertext.
- enc_result_valid  input  NUM_ENCRYPTERS  per-lane result available; held until acked.
- enc_result_ack  output  NUM_ENCRYPTERS  one-cycle pulse per lane on capture.
- qspi_out_data  output  4  current nibble.
- qspi_out_valid  output  1  nibble valid.
- qspi_out_ready  input  1  sink accepts the nibble.
- qspi_out_sending  output  1  high while a session is open.
- lane_ptr_out  output  clog2(NUM_ENCRYPTERS)  watcher: next lane to collect.
- packets_sent  output  COUNT_WIDTH  watcher: packets fully shifted out.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE.
  - All outputs 0; lane_ptr=0, packets_sent=0.
  - Packet buffer and nibble index cleared; a packet in flight is discarded and never acked twice.
- States: IDLE, WAIT, SHIFT.
- IDLE:
  - start=1 → WAIT, lane_ptr=0, qspi_out_sending=1.
  - flush is ignored in IDLE.
- WAIT:
  - flush=1 → IDLE, qspi_out_sending=0.
  - Otherwise, if enc_result_valid[lane_ptr]=1:
    - Capture enc_result_data[lane_ptr] into the buffer.
    - enc_result_ack[lane_ptr]=1 for exactly the next cycle.
    - lane_ptr increments, wrapping from NUM_ENCRYPTERS-1 to 0.
    - nib_idx=0; go to SHIFT.
- SHIFT:
  - qspi_out_valid=1 and qspi_out_data=buffer[nib_idx*4 +: 4]. Order is LSB nibble first, matching the upstream packing order.
  - On qspi_out_valid & qspi_out_ready, nib_idx increments.
  - On acceptance of nibble ENCRYPTER_WIDTH/4-1:
    - packets_sent increments (wraps at 2^COUNT_WIDTH).
    - If flush=1 → IDLE, else → WAIT.
  - qspi_out_data must stay stable while valid=1 and ready=0.
- Latency: capture edge to first nibble valid is 1 cycle. With ready tied high, one packet takes ENCRYPTER_WIDTH/4 cycles of SHIFT plus at least 1 cycle in WAIT.
- Ordering:
  - valid on any lane other than lane_ptr is ignored, even if it arrives first; the block stalls until lane_ptr's lane is valid.
  - No timeout.
- Simultaneous events:
  - start while not IDLE is ignored.
  - flush together with valid in WAIT: flush wins and nothing is captured.
  - flush during SHIFT: the current packet completes, then → IDLE.
- enc_result_ack is never asserted for more than one cycle or for more than one lane at a time.

Optional Feature:
- COLLECTOR_DOUBLE_BUF_EN defined:
  - Adds a second packet register.
  - During SHIFT, if the holding register is empty and enc_result_valid[lane_ptr]=1, capture into the holding register, ack, and advance lane_ptr.
  - On the last nibble, if the holding register is full, move it to the shift buffer and stay in SHIFT. This gives back-to-back packets with zero idle cycles.
  - flush only leaves SHIFT when the holding register is empty.
- Not defined:
  - Single buffer; at least 1 WAIT cycle between packets.
  - No capture while in SHIFT.

Decomposition:
- Shared package yoda_pkg holds:
  - NUM_ENCRYPTERS, ENCRYPTER_WIDTH, NIBBLE_WIDTH=4.
  - Derived constants: ENCRYPTER_QSPI_COUNT=ENCRYPTER_WIDTH/4 and the lane index width.
  - The collector state enum typedef.
- One natural sub-module: nibble_shifter. It takes a load/packet input, drives the valid/ready nibble output, and emits a done pulse. It is reused in the double-buffer build.

Test Plan:
- Reset, start, lanes 0..3 valid with 0x11111111, 0x22222222, 0x33333333, 0x44444444, ready=1 → nibbles 1×8, 2×8, 3×8, 4×8 in order; one ack per lane; packets_sent=4; lane_ptr back to 0.
- Lane 2 valid before lane 1 → no ack to lane 2 until lane 1 has been captured; output order stays lane1 then lane2.
- Packet 0x87654321 with ready toggling 1,0,0,1,… → nibbles 1,2,…,8 each held stable while ready=0; no nibble dropped or duplicated.
- flush asserted at nibble 3 of a packet → remaining nibbles 4..8 still sent; then IDLE, qspi_out_sending=0; a later valid on lane 1 gets no ack.
- reset pulled low mid-SHIFT at nibble 5 → all outputs 0 immediately; after release, a start plus a lane 0 packet is collected normally with packets_sent=1.
- With COLLECTOR_DOUBLE_BUF_EN and all lanes continuously valid, ready=1 → 32 consecutive valid cycles with no gap; without the macro, exactly 1 gap cycle between packets.
